// File: rtl/calc_sequencer_if.sv
// ============================================================================
// Module   : calc_sequencer_if
// Brief    : Handshake bundle between calc_sequencer and its datapath peers.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface calc_sequencer_if;
  logic       pl_start;
  logic       core_busy;
  logic       core_start;
  logic [2:0] regime_in;
  logic       ol_busy;
  logic       ol_start;
  logic [2:0] ol_mode;
  logic       seq_busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       overrun;
  logic       clr_err;

  // The sequencer side issues the kicks and reports status.
  modport master (
    input  pl_start,
    input  core_busy,
    input  regime_in,
    input  ol_busy,
    input  clr_err,
    output core_start,
    output ol_start,
    output ol_mode,
    output seq_busy,
    output done,
    output err,
    output err_code,
    output overrun
  );

  modport slave (
    output pl_start,
    output core_busy,
    output regime_in,
    output ol_busy,
    output clr_err,
    input  core_start,
    input  ol_start,
    input  ol_mode,
    input  seq_busy,
    input  done,
    input  err,
    input  err_code,
    input  overrun
  );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module   : calc_sequencer
// Brief    : Sequences param load -> eig_core run -> output streaming with
//            handshake timeouts, sticky error and overrun reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_sequencer #(
  parameter int ACK_TO  = 15,
  parameter int CORE_TO = 255,
  parameter int OL_TO   = 255,
  parameter int CW      = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  calc_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    C_KICK = 4'd1,
    C_ACK  = 4'd2,
    C_RUN  = 4'd3,
    O_KICK = 4'd4,
    O_ACK  = 4'd5,
    O_RUN  = 4'd6,
    DONE   = 4'd7,
    ERROR  = 4'd8
  } state_t;

  localparam logic [CW-1:0] c_ack_lim  = CW'(ACK_TO);
  localparam logic [CW-1:0] c_core_lim = CW'(CORE_TO);
  localparam logic [CW-1:0] c_ol_lim   = CW'(OL_TO);

  localparam logic [1:0] c_err_none = 2'b00;
  localparam logic [1:0] c_err_ack  = 2'b01;
  localparam logic [1:0] c_err_core = 2'b10;
  localparam logic [1:0] c_err_ol   = 2'b11;

  state_t        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q,  overrun_d;
  logic [2:0]    ol_mode_q,  ol_mode_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_code_q <= c_err_none;
      overrun_q  <= 1'b0;
      ol_mode_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      overrun_q  <= overrun_d;
      ol_mode_q  <= ol_mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    overrun_d  = overrun_q;
    ol_mode_d  = ol_mode_q;

    // clr_err takes priority, so a request dropped in ERROR is not flagged.
    if (bus.clr_err) begin
      err_code_d = c_err_none;
      overrun_d  = 1'b0;
    end else if (bus.pl_start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.pl_start) begin
          state_d = C_KICK;
        end
      end

      C_KICK: begin
        state_d = C_ACK;
        cnt_d   = '0;
      end

      C_ACK: begin
        if (bus.core_busy) begin
          state_d = C_RUN;
          cnt_d   = '0;
        end else if (cnt_q == c_ack_lim) begin
          state_d    = ERROR;
          err_code_d = c_err_ack;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      C_RUN: begin
        if (!bus.core_busy) begin
          state_d   = O_KICK;
          ol_mode_d = bus.regime_in;
        end else if (cnt_q == c_core_lim) begin
          state_d    = ERROR;
          err_code_d = c_err_core;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      O_KICK: begin
        state_d = O_ACK;
        cnt_d   = '0;
      end

      O_ACK: begin
        if (bus.ol_busy) begin
          state_d = O_RUN;
          cnt_d   = '0;
        end else if (cnt_q == c_ack_lim) begin
          state_d    = ERROR;
          err_code_d = c_err_ack;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      O_RUN: begin
        if (!bus.ol_busy) begin
          state_d = DONE;
        end else if (cnt_q == c_ol_lim) begin
          state_d    = ERROR;
          err_code_d = c_err_ol;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERROR: begin
        if (bus.clr_err) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.core_start = (state_q == C_KICK);
  assign bus.ol_start   = (state_q == O_KICK);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ERROR);
  assign bus.seq_busy   = (state_q != IDLE) && (state_q != ERROR);
  assign bus.err_code   = err_code_q;
  assign bus.overrun    = overrun_q;
  assign bus.ol_mode    = ol_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Scoreboard bench: expected pulse/error events are queued by the
//            stimulus and popped by a negedge monitor as the DUT emits them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

  localparam int EV_CSTART = 1;
  localparam int EV_OSTART = 2;
  localparam int EV_DONE   = 3;
  localparam int EV_ERR    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  calc_sequencer_if bus();

  calc_sequencer #(
    .ACK_TO  (15),
    .CORE_TO (255),
    .OL_TO   (255),
    .CW      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         at;
    logic [2:0] mode;
    logic [1:0] code;
    logic       ov;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic err_prev = 1'b0;

  function automatic void expect_ev(input int kind, input int at, input logic [2:0] mode,
                                    input logic [1:0] code, input logic ov);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.mode = mode;
    e.code = code;
    e.ov   = ov;
    exp_q.push_back(e);
  endfunction

  // Monitor: every pulse or error entry must match the head of the queue.
  always @(negedge clk) begin : mon
    int  k;
    ev_t e;
    k = 0;
    if (bus.core_start)              k = EV_CSTART;
    else if (bus.ol_start)           k = EV_OSTART;
    else if (bus.done)               k = EV_DONE;
    else if (bus.err && !err_prev)   k = EV_ERR;
    err_prev = bus.err;
    if (k != 0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, required no event", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.at != cyc || e.mode !== bus.ol_mode ||
            e.code !== bus.err_code || e.ov !== bus.overrun) begin
          fails++;
          $display("FAIL event: got kind=%0d cyc=%0d mode=%b code=%b ov=%b, required kind=%0d cyc=%0d mode=%b code=%b ov=%b",
                   k, cyc, bus.ol_mode, bus.err_code, bus.overrun,
                   e.kind, e.at, e.mode, e.code, e.ov);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // {core_start, ol_start, ol_mode, seq_busy, done, err, err_code, overrun}
  function automatic logic [31:0] outs();
    return {21'd0, bus.core_start, bus.ol_start, bus.ol_mode, bus.seq_busy,
            bus.done, bus.err, bus.err_code, bus.overrun};
  endfunction

  function automatic logic [31:0] idle_outs(input logic [2:0] mode);
    return {21'd0, 1'b0, 1'b0, mode, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  endfunction

  task automatic idle_inputs();
    bus.pl_start  = 1'b0;
    bus.core_busy = 1'b0;
    bus.ol_busy   = 1'b0;
    bus.clr_err   = 1'b0;
    rst_n         = 1'b1;
  endtask

  // Drives one sequence: pl_start at rel 0 (and optionally at pl2), busy windows
  // [lo,hi] relative to the start cycle, optional one-cycle reset at rst_at.
  task automatic run_profile(input int len, input int cb_lo, input int cb_hi,
                             input int ob_lo, input int ob_hi, input int pl2,
                             input int rst_at, input logic [2:0] rv);
    for (int r = 0; r < len; r++) begin
      bus.pl_start  = (r == 0) || (r == pl2);
      bus.core_busy = (r >= cb_lo) && (r <= cb_hi);
      bus.ol_busy   = (r >= ob_lo) && (r <= ob_hi);
      bus.regime_in = rv;
      rst_n         = (r != rst_at);
      tick();
    end
    idle_inputs();
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  initial begin : stim
    int t0;
    idle_inputs();
    bus.regime_in = 3'b000;
    rst_n         = 1'b0;
    bus.pl_start  = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", outs(), idle_outs(3'b000));
    rst_n        = 1'b1;
    bus.pl_start = 1'b0;
    tick();
    chk("post_reset_idle", outs(), idle_outs(3'b000));

    // Nominal sequence
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,  3'b000, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 13, 3'b101, 2'b00, 1'b0);
    expect_ev(EV_DONE,   t0 + 32, 3'b101, 2'b00, 1'b0);
    run_profile(33, 2, 11, 14, 30, -1, -1, 3'b101);
    chk("nominal_after_done", outs(), idle_outs(3'b101));

    // Core acknowledge timeout
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,  3'b101, 2'b00, 1'b0);
    expect_ev(EV_ERR,    t0 + 18, 3'b101, 2'b01, 1'b0);
    run_profile(19, -1, -1, -1, -1, -1, -1, 3'b110);
    chk("ack_to_state", {28'd0, bus.err, bus.err_code, bus.seq_busy}, 32'b1010);
    pulse_clr();
    chk("ack_to_cleared", outs(), idle_outs(3'b101));

    // Core run timeout boundary: busy falls exactly on the cnt==limit cycle
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,   3'b101, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 259, 3'b010, 2'b00, 1'b0);
    expect_ev(EV_DONE,   t0 + 267, 3'b010, 2'b00, 1'b0);
    run_profile(268, 2, 257, 260, 265, -1, -1, 3'b010);
    chk("core_to_boundary_ok", outs(), idle_outs(3'b010));

    // One cycle longer trips the run timeout
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,   3'b010, 2'b00, 1'b0);
    expect_ev(EV_ERR,    t0 + 259, 3'b010, 2'b10, 1'b0);
    run_profile(261, 2, 258, -1, -1, -1, -1, 3'b111);
    chk("core_to_code", {29'd0, bus.err, bus.err_code}, 32'b110);
    pulse_clr();
    chk("core_to_cleared", outs(), idle_outs(3'b010));

    // Output run timeout with ol_busy stuck
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,   3'b010, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 5,   3'b011, 2'b00, 1'b0);
    expect_ev(EV_ERR,    t0 + 263, 3'b011, 2'b11, 1'b0);
    run_profile(265, 2, 3, 6, 264, -1, -1, 3'b011);
    chk("ol_to_state", {26'd0, bus.ol_mode, bus.err, bus.err_code}, 32'b011111);
    pulse_clr();
    chk("ol_to_mode_kept", outs(), idle_outs(3'b011));

    // Overrun: second request during C_RUN is ignored but flagged
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,  3'b011, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 13, 3'b101, 2'b00, 1'b1);
    expect_ev(EV_DONE,   t0 + 32, 3'b101, 2'b00, 1'b1);
    run_profile(33, 2, 11, 14, 30, 5, -1, 3'b101);
    chk("overrun_set", outs(), idle_outs(3'b101) | 32'd1);
    pulse_clr();
    chk("overrun_cleared", outs(), idle_outs(3'b101));

    // Reset during O_RUN aborts with no done
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,  3'b101, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 13, 3'b110, 2'b00, 1'b0);
    run_profile(21, 2, 11, 14, 30, -1, 20, 3'b110);
    chk("reset_mid_run", outs(), idle_outs(3'b000));

    // Fresh sequence after the abort
    t0 = cyc;
    expect_ev(EV_CSTART, t0 + 1,  3'b000, 2'b00, 1'b0);
    expect_ev(EV_OSTART, t0 + 13, 3'b100, 2'b00, 1'b0);
    expect_ev(EV_DONE,   t0 + 32, 3'b100, 2'b00, 1'b0);
    run_profile(33, 2, 11, 14, 30, -1, -1, 3'b100);
    chk("fresh_after_reset", outs(), idle_outs(3'b100));

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_event: got none, required kind=%0d at cyc=%0d", e.kind, e.at);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
